// File: rtl/mod12_job_arbiter.sv
// mod12_job_arbiter
//   Shares one external mod-12 up/down counter between two requesters.
//   Each requester submits a job (start value, direction, step count). The
//   block grants round-robin, loads the counter, lets it run for the requested
//   number of steps and reports the final count. The counter has no enable, so
//   whenever no job is running the block holds it by reloading its own value.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0/dir0/start0/steps0     requester 0: level request and job fields
//   req1/dir1/start1/steps1     requester 1: level request and job fields
//   gnt[1:0]                    one-hot owner of the counter (grant..DONE/ERR)
//   done[1:0]                   one-cycle completion pulse to the owner
//   err                         qualifies done: job rejected (start > CNT_MAX)
//   result[3:0]                 final counter value, valid while done != 0
//   busy                        job in progress
//   cnt_load/cnt_mode/cnt_datain  counter controls (mode 1 = up)
//   cnt_dataout                 counter current value

module mod12_job_arbiter #(
    parameter int STEP_W  = 5,
    parameter int CNT_MAX = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              dir0,
    input  logic [3:0]        start0,
    input  logic [STEP_W-1:0] steps0,
    input  logic              req1,
    input  logic              dir1,
    input  logic [3:0]        start1,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic [3:0]        result,
    output logic              busy,
    output logic              cnt_load,
    output logic              cnt_mode,
    output logic [3:0]        cnt_datain,
    input  logic [3:0]        cnt_dataout
);

    localparam logic [3:0] CNT_MAX_L = 4'(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic              rr_last;     // requester granted most recently
    logic              owner;
    logic [STEP_W-1:0] remaining;
    logic [3:0]        result_q;

    logic              job_dir;
    logic [3:0]        job_start;
    logic [STEP_W-1:0] job_steps;

    logic              any_req;
    logic              win;
    logic              win_dir;
    logic [3:0]        win_start;
    logic [STEP_W-1:0] win_steps;
    logic              grant;

    // Arbitration: a lone requester wins; on contention the one not granted
    // last time wins.
    always_comb begin
        any_req   = req0 | req1;
        win       = (req0 && req1) ? ~rr_last : req1;
        win_dir   = win ? dir1   : dir0;
        win_start = win ? start1 : start0;
        win_steps = win ? steps1 : steps0;
        grant     = (state == S_IDLE) && any_req;
    end

    // Job fields are sampled only at the grant edge.
    always_ff @(posedge clk) begin
        if (grant) begin
            job_dir   <= win_dir;
            job_start <= win_start;
            job_steps <= win_steps;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt       <= 2'b00;
            done      <= 2'b00;
            err       <= 1'b0;
            busy      <= 1'b0;
            rr_last   <= 1'b1;
            owner     <= 1'b0;
            remaining <= '0;
            result_q  <= 4'd0;
        end else begin
            done <= 2'b00;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner   <= win;
                        rr_last <= win;
                        gnt     <= win ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        if (win_start <= CNT_MAX_L) begin
                            state <= S_LOAD;
                        end else begin
                            // Rejected job: report immediately, counter untouched.
                            state <= S_ERR;
                            done  <= win ? 2'b10 : 2'b01;
                            err   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    remaining <= job_steps;
                    if (job_steps == '0) begin
                        state <= S_DONE;
                        done  <= owner ? 2'b10 : 2'b01;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    remaining <= remaining - STEP_W'(1);
                    if (remaining == STEP_W'(1)) begin
                        state <= S_DONE;
                        done  <= owner ? 2'b10 : 2'b01;
                    end
                end
                S_DONE, S_ERR: begin
                    result_q <= cnt_dataout;
                    state    <= S_IDLE;
                    gnt      <= 2'b00;
                    busy     <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counter drive is a pure decode of state and the latched job; every
    // state other than LOAD/RUN reloads the counter with its own value.
    always_comb begin
        cnt_load   = 1'b1;
        cnt_mode   = 1'b0;
        cnt_datain = cnt_dataout;
        case (state)
            S_LOAD: begin
                cnt_datain = job_start;
                cnt_mode   = job_dir;
            end
            S_RUN: begin
                cnt_load = 1'b0;
                cnt_mode = job_dir;
            end
            default: ;
        endcase
    end

    // During DONE/ERR the counter already holds the final value.
    assign result = (state == S_DONE || state == S_ERR) ? cnt_dataout : result_q;

endmodule
